// File: rtl/add_result_accum.sv
// add_result_accum: accumulates BURST adder results (sum + carry-out) into a
// WIDTH-bit running total, counts carry events (saturating) and keeps a
// sticky carry flag, then presents the burst result on a valid/ready output.
// Optional build macro: ACC_SATURATE_EN - the accumulator clamps to all ones
// on overflow instead of wrapping.
module add_result_accum #(
    parameter int WIDTH = 64,
    parameter int BURST = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_ca,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_acc,
    output logic [CNT_W-1:0] out_carry_cnt,
    output logic             out_sticky
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic [7:0]       LAST_BEAT = 8'(BURST - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt;
    logic [CNT_W-1:0] carry_cnt, carry_cnt_nxt;
    logic             sticky, sticky_nxt;
    logic [7:0]       beat_cnt, beat_cnt_nxt;

    logic [WIDTH:0]   sum_ext;
    logic             ovf;
    logic [1:0]       events;
    logic [CNT_W:0]   cnt_sum;
    logic [WIDTH-1:0] acc_add;
    logic [CNT_W-1:0] cnt_add;
    logic             beat_fire;

    // Per-beat arithmetic: widened add, carry-event count, saturating counter
    always_comb begin
        sum_ext = {1'b0, acc} + {1'b0, in_sum};
        ovf     = sum_ext[WIDTH];
        events  = {1'b0, ovf} + {1'b0, in_ca};
        cnt_sum = {1'b0, carry_cnt} + (CNT_W + 1)'(events);
        cnt_add = cnt_sum[CNT_W] ? CNT_MAX : cnt_sum[CNT_W-1:0];
`ifdef ACC_SATURATE_EN
        // Once clamped, any further nonzero add overflows again, so the
        // accumulator stays all ones for the remainder of the burst.
        acc_add = ovf ? '1 : sum_ext[WIDTH-1:0];
`else
        acc_add = sum_ext[WIDTH-1:0];
`endif
    end

    // Handshake outputs and next-state / next-datapath selection
    always_comb begin
        in_ready      = (state == ACCUM) && !clear && !rst;
        out_valid     = (state == HOLD);
        beat_fire     = in_valid && in_ready;
        state_nxt     = state;
        acc_nxt       = acc;
        carry_cnt_nxt = carry_cnt;
        sticky_nxt    = sticky;
        beat_cnt_nxt  = beat_cnt;
        if (clear) begin
            state_nxt     = ACCUM;
            acc_nxt       = '0;
            carry_cnt_nxt = '0;
            sticky_nxt    = 1'b0;
            beat_cnt_nxt  = '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (beat_fire) begin
                        acc_nxt       = acc_add;
                        carry_cnt_nxt = cnt_add;
                        sticky_nxt    = sticky | (events != 2'd0);
                        beat_cnt_nxt  = beat_cnt + 8'd1;
                        if (beat_cnt == LAST_BEAT) begin
                            state_nxt = HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_nxt     = ACCUM;
                        acc_nxt       = '0;
                        carry_cnt_nxt = '0;
                        sticky_nxt    = 1'b0;
                        beat_cnt_nxt  = '0;
                    end
                end
                default: state_nxt = ACCUM;
            endcase
        end
    end

    // State and accumulation registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACCUM;
            acc       <= '0;
            carry_cnt <= '0;
            sticky    <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            carry_cnt <= carry_cnt_nxt;
            sticky    <= sticky_nxt;
            beat_cnt  <= beat_cnt_nxt;
        end
    end

    // Running totals are exposed directly; stable in HOLD since nothing updates
    always_comb begin
        out_acc       = acc;
        out_carry_cnt = carry_cnt;
        out_sticky    = sticky;
    end

endmodule

// File: tb/tb_add_result_accum.sv
// Directed bench for add_result_accum: table of 4-beat bursts plus hand-written
// sequences for backpressure, clear, async reset and counter saturation.
module tb_add_result_accum;

    logic        clk;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_sum;
    logic        in_ca;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_acc;
    logic [7:0]  out_carry_cnt;
    logic        out_sticky;

    logic        in_valid2;
    logic        in_ready2;
    logic [7:0]  in_sum2;
    logic        in_ca2;
    logic        out_valid2;
    logic        out_ready2;
    logic [7:0]  out_acc2;
    logic [1:0]  out_carry_cnt2;
    logic        out_sticky2;

    int n_cmp = 0;
    int n_bad = 0;

    add_result_accum #(.WIDTH(64), .BURST(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .in_ca(in_ca),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc),
        .out_carry_cnt(out_carry_cnt), .out_sticky(out_sticky)
    );

    add_result_accum #(.WIDTH(8), .BURST(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .clear(clear),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_sum(in_sum2), .in_ca(in_ca2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_acc(out_acc2),
        .out_carry_cnt(out_carry_cnt2), .out_sticky(out_sticky2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [3:0][63:0] s;
        logic [3:0]      ca;
        logic [63:0]     acc;
        logic [7:0]      cnt;
        logic            st;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input string nm, input logic [63:0] s0, s1, s2, s3,
                                input logic [3:0] ca, input logic [63:0] acc,
                                input logic [7:0] cnt, input logic st);
        vec_t v;
        v.name = nm;
        v.s[0] = s0; v.s[1] = s1; v.s[2] = s2; v.s[3] = s3;
        v.ca = ca; v.acc = acc; v.cnt = cnt; v.st = st;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_beat(input logic [63:0] s, input logic c);
        @(negedge clk);
        in_valid = 1'b1;
        in_sum   = s;
        in_ca    = c;
        #1 chk("in_ready_beat", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
    endtask

    task automatic end_beats;
        @(negedge clk);
        in_valid = 1'b0;
        in_ca    = 1'b0;
        in_sum   = '0;
        #1;
    endtask

    task automatic take_result;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        chk("post_xfer_valid", {63'd0, out_valid}, 64'd0);
        chk("post_xfer_ready", {63'd0, in_ready}, 64'd1);
        chk("post_xfer_acc", out_acc, 64'd0);
        chk("post_xfer_cnt", {56'd0, out_carry_cnt}, 64'd0);
    endtask

    task automatic run_vec(input vec_t v);
        for (int i = 0; i < 4; i++) drive_beat(v.s[i], v.ca[i]);
        end_beats();
        chk({v.name, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({v.name, "_in_ready"}, {63'd0, in_ready}, 64'd0);
        chk({v.name, "_acc"}, out_acc, v.acc);
        chk({v.name, "_cnt"}, {56'd0, out_carry_cnt}, {56'd0, v.cnt});
        chk({v.name, "_sticky"}, {63'd0, out_sticky}, {63'd0, v.st});
        take_result();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_sum = '0; in_ca = 1'b0; out_ready = 1'b0;
        in_valid2 = 1'b0; in_sum2 = '0; in_ca2 = 1'b0; out_ready2 = 1'b0;

        vecs[0] = mk("basic", 64'd1, 64'd16, 64'd0, 64'd3, 4'b0000, 64'd20, 8'd0, 1'b0);
`ifdef ACC_SATURATE_EN
        vecs[1] = mk("ovf_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd0, 64'd0, 4'b0000,
                     64'hFFFF_FFFF_FFFF_FFFF, 8'd1, 1'b1);
        vecs[3] = mk("ovf_and_ca", 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0, 4'b0010,
                     64'hFFFF_FFFF_FFFF_FFFF, 8'd2, 1'b1);
        vecs[4] = mk("msb_mix", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                     64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b0101,
                     64'hFFFF_FFFF_FFFF_FFFF, 8'd5, 1'b1);
`else
        vecs[1] = mk("ovf_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'd0, 64'd0, 4'b0000,
                     64'd2, 8'd1, 1'b1);
        vecs[3] = mk("ovf_and_ca", 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'd0, 4'b0010,
                     64'd0, 8'd2, 1'b1);
        vecs[4] = mk("msb_mix", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                     64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b0101,
                     64'd0, 8'd4, 1'b1);
`endif
        vecs[2] = mk("ca_only", 64'd0, 64'd0, 64'd0, 64'd0, 4'b1111, 64'd0, 8'd4, 1'b1);
        vecs[5] = mk("no_carry", 64'h1234, 64'h10_0000_0000, 64'hFFFF, 64'd1, 4'b0000,
                     64'h10_0001_1234, 8'd0, 1'b0);

        // reset state while rst held
        #2;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_acc", out_acc, 64'd0);
        chk("rst_cnt", {56'd0, out_carry_cnt}, 64'd0);
        chk("rst_sticky", {63'd0, out_sticky}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("rel_in_ready", {63'd0, in_ready}, 64'd1);

        for (int k = 0; k < 6; k++) run_vec(vecs[k]);

        // backpressure: 5 stalled cycles with in_valid asserted
        for (int i = 0; i < 4; i++) drive_beat(64'd2, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_sum = 64'd99; in_ca = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_acc", out_acc, 64'd8);
            chk("bp_sticky", {63'd0, out_sticky}, 64'd0);
            @(negedge clk);
        end
        in_valid = 1'b0; in_ca = 1'b0;
        take_result();
        #1 chk("bp_once", {63'd0, out_valid}, 64'd0);
        run_vec(mk("bp_next", 64'd1, 64'd1, 64'd1, 64'd1, 4'b0000, 64'd4, 8'd0, 1'b0));

        // clear after 2 beats, with a beat offered in the clear cycle
        drive_beat(64'd5, 1'b1);
        drive_beat(64'd7, 1'b0);
        @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; in_sum = 64'd100;
        #1 chk("clr_in_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        clear = 1'b0; in_valid = 1'b0;
        #1;
        chk("clr_acc", out_acc, 64'd0);
        chk("clr_sticky", {63'd0, out_sticky}, 64'd0);
        run_vec(mk("after_clr", 64'd1, 64'd1, 64'd1, 64'd1, 4'b0000, 64'd4, 8'd0, 1'b0));

        // clear drops a pending result
        for (int i = 0; i < 4; i++) drive_beat(64'd9, 1'b0);
        end_beats();
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        #1;
        chk("clr_hold_valid", {63'd0, out_valid}, 64'd0);
        chk("clr_hold_acc", out_acc, 64'd0);
        chk("clr_hold_ready", {63'd0, in_ready}, 64'd1);

        // async reset mid-burst, between edges
        drive_beat(64'd5, 1'b1);
        drive_beat(64'd6, 1'b0);
        end_beats();
        chk("pre_rst_acc", out_acc, 64'd11);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_acc", out_acc, 64'd0);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("arst_cnt", {56'd0, out_carry_cnt}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 chk("arst_rel_ready", {63'd0, in_ready}, 64'd1);
        run_vec(mk("after_rst", 64'd2, 64'd3, 64'd4, 64'd5, 4'b0000, 64'd14, 8'd0, 1'b0));

        // narrow instance: BURST=3, 2-bit counter saturates at 3
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid2 = 1'b1;
            in_sum2   = (i == 2) ? 8'h00 : 8'hFF;
            in_ca2    = 1'b1;
            #1 chk("n_in_ready", {63'd0, in_ready2}, 64'd1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid2 = 1'b0; in_ca2 = 1'b0;
        #1;
        chk("n_valid", {63'd0, out_valid2}, 64'd1);
`ifdef ACC_SATURATE_EN
        chk("n_acc", {56'd0, out_acc2}, 64'hFF);
`else
        chk("n_acc", {56'd0, out_acc2}, 64'hFE);
`endif
        chk("n_cnt_sat", {62'd0, out_carry_cnt2}, 64'd3);
        chk("n_sticky", {63'd0, out_sticky2}, 64'd1);
        out_ready2 = 1'b1;
        @(negedge clk);
        out_ready2 = 1'b0;
        #1;
        chk("n_post_valid", {63'd0, out_valid2}, 64'd0);
        chk("n_post_cnt", {62'd0, out_carry_cnt2}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
